gpio0_in_debounce: RTL and testbench

// - Input conditioning stage directly upstream of the GPIO0 controller.
// - Synchronises raw pad inputs into the pclk domain and applies an optional per-bit

---
 rtl/gpio0_in_debounce.sv | 119 +++++++++++
 tb/tb_gpio0_in_debounce.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio0_in_debounce.sv
// gpio0_in_debounce
// Input conditioning in front of the GPIO0 controller: a two-flop synchroniser
// per pad bit, a shared sample-tick prescaler and a per-bit glitch filter.
// The filter lets a bit change only after the pad has been seen at its new
// level for db_thresh+1 consecutive sample ticks. Bits with db_en clear skip
// the filter and simply follow the synchronised pad. gpio_in_chg flags,
// for one cycle, every bit whose conditioned value has just changed.
module gpio0_in_debounce #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 4,
   parameter int DIV_W = 16
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic [WIDTH-1:0] pad_in,
   input  logic [WIDTH-1:0] db_en,
   input  logic [DIV_W-1:0] db_div,
   input  logic [CNT_W-1:0] db_thresh,
   output logic [WIDTH-1:0] gpio_ext_porta,
   output logic [WIDTH-1:0] gpio_in_chg,
   output logic             db_tick
);

   // Metastability chain; sync1 feeds nothing but sync2.
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;

   // Shared prescaler; tick is the combinational terminal-count decode.
   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   // Per-bit stability counters and next-state values of the filter.
   logic [WIDTH-1:0][CNT_W-1:0] cnt;
   logic [WIDTH-1:0][CNT_W-1:0] cnt_next;
   logic [WIDTH-1:0]            out_next;

   // Next state of one filter bit, given its synchronised level and current state.
   function automatic logic [CNT_W:0] filter_bit(
      input logic             en,
      input logic             lvl,
      input logic             cur,
      input logic [CNT_W-1:0] count,
      input logic             smp,
      input logic [CNT_W-1:0] thresh
   );
      // Result packs {new_out, new_count}.
      logic             nout;
      logic [CNT_W-1:0] ncnt;
      nout = cur;
      ncnt = count;
      if (!en) begin
         nout = lvl;
         ncnt = '0;
      end else if (lvl == cur) begin
         // Level agrees with output: any partial evidence is discarded.
         ncnt = '0;
      end else if (smp) begin
         // >= so that lowering thresh at runtime accepts at the next tick.
         if (count >= thresh) begin
            nout = lvl;
            ncnt = '0;
         end else begin
            ncnt = count + 1'b1;
         end
      end
      return {nout, ncnt};
   endfunction

   // ---- stage: pad -> sync1 -> sync2
   // Two-flop synchroniser for the asynchronous pad inputs.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pad_in;
         sync2 <= sync1;
      end
   end

   assign tick = (div_cnt == db_div);

   // Prescaler: counts 0..db_div, wraps on tick; db_tick is tick delayed one cycle.
   // If db_div drops below div_cnt the counter runs to its maximum and wraps silently.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         div_cnt <= '0;
         db_tick <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         db_tick <= tick;
      end
   end

   // Evaluate every bit's filter independently.
   always_comb begin
      out_next = gpio_ext_porta;
      cnt_next = cnt;
      for (int i = 0; i < WIDTH; i++) begin
         {out_next[i], cnt_next[i]} = filter_bit(db_en[i], sync2[i], gpio_ext_porta[i],
                                                 cnt[i], tick, db_thresh);
      end
   end

   // ---- stage: sync2 -> gpio_ext_porta / gpio_in_chg
   // Output register, counters and change strobe aligned with the new output value.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         gpio_ext_porta <= '0;
         gpio_in_chg    <= '0;
         cnt            <= '0;
      end else begin
         gpio_ext_porta <= out_next;
         gpio_in_chg    <= out_next ^ gpio_ext_porta;
         cnt            <= cnt_next;
      end
   end

endmodule

// File: tb/tb_gpio0_in_debounce.sv
// tb_gpio0_in_debounce
// Scoreboard bench: each cycle the reference model predicts the outputs that
// the coming clock edge should produce, queues them, and the queue entry is
// compared against the DUT one time unit after that edge. Directed checks on
// latency, acceptance timing and reset behaviour are layered on top.
module tb_gpio0_in_debounce;

   logic        pclk;
   logic        presetn;
   logic [31:0] pad_in;
   logic [31:0] db_en;
   logic [15:0] db_div;
   logic [3:0]  db_thresh;
   logic [31:0] gpio_ext_porta;
   logic [31:0] gpio_in_chg;
   logic        db_tick;

   gpio0_in_debounce #(.WIDTH(32), .CNT_W(4), .DIV_W(16)) dut (
      .pclk          (pclk),
      .presetn       (presetn),
      .pad_in        (pad_in),
      .db_en         (db_en),
      .db_div        (db_div),
      .db_thresh     (db_thresh),
      .gpio_ext_porta(gpio_ext_porta),
      .gpio_in_chg   (gpio_in_chg),
      .db_tick       (db_tick)
   );

   typedef struct {
      logic [31:0] porta;
      logic [31:0] chg;
      logic        tick;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   // Reference model state
   logic [31:0] m_s1, m_s2, m_out;
   logic [15:0] m_div;
   logic [3:0]  m_cnt [32];

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1  = '0;
      m_s2  = '0;
      m_out = '0;
      m_div = '0;
      for (int i = 0; i < 32; i++) m_cnt[i] = '0;
   endtask

   // Predict the outputs produced by the next clock edge from the present inputs.
   task automatic model_step(output exp_t e);
      logic        tk;
      logic [31:0] nout;
      tk   = (m_div == db_div);
      nout = m_out;
      for (int i = 0; i < 32; i++) begin
         if (db_en[i] == 1'b0) begin
            nout[i]  = m_s2[i];
            m_cnt[i] = 4'd0;
         end else if (m_s2[i] != m_out[i]) begin
            if (tk && m_cnt[i] >= db_thresh) begin
               nout[i]  = m_s2[i];
               m_cnt[i] = 4'd0;
            end else if (tk) begin
               m_cnt[i] = m_cnt[i] + 4'd1;
            end
         end else begin
            m_cnt[i] = 4'd0;
         end
      end
      e.porta = nout;
      e.chg   = nout ^ m_out;
      e.tick  = tk;
      m_out   = nout;
      m_div   = tk ? 16'd0 : m_div + 16'd1;
      m_s2    = m_s1;
      m_s1    = pad_in;
   endtask

   // One clock: queue the prediction, let the edge happen, compare.
   task automatic cyc();
      exp_t e;
      exp_t g;
      model_step(e);
      sb_q.push_back(e);
      @(posedge pclk);
      #1;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 32'd0, 32'd1);
      end else begin
         g = sb_q.pop_front();
         check_val("porta", gpio_ext_porta, g.porta);
         check_val("chg", gpio_in_chg, g.chg);
         check_val("tick", {31'b0, db_tick}, {31'b0, g.tick});
      end
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_porta"}, gpio_ext_porta, 32'h0);
      check_val({tag, "_chg"}, gpio_in_chg, 32'h0);
      check_val({tag, "_tick"}, {31'b0, db_tick}, 32'h0);
   endtask

   initial begin
      int rise;
      int pulses;
      int last_tick;
      int tick_gap;
      logic hit;

      // Reset with all pads high: everything held at zero.
      presetn   = 1'b0;
      pad_in    = 32'hFFFF_FFFF;
      db_en     = 32'h0;
      db_div    = 16'd0;
      db_thresh = 4'd0;
      model_reset();
      repeat (3) @(posedge pclk);
      #1;
      check_zero("in_reset");
      presetn = 1'b1;

      // Sync-only path: all ones after the third edge, one change strobe.
      for (int k = 1; k <= 4; k++) begin
         cyc();
         if (k == 2) check_val("rel_porta2", gpio_ext_porta, 32'h0);
         if (k == 3) check_val("rel_porta3", gpio_ext_porta, 32'hFFFF_FFFF);
         if (k == 3) check_val("rel_chg3", gpio_in_chg, 32'hFFFF_FFFF);
         if (k == 4) check_val("rel_chg4", gpio_in_chg, 32'h0);
      end

      // Bypass latency on bit 5.
      pad_in = 32'h0;
      repeat (4) cyc();
      pad_in = 32'h20;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         if (k == 2) check_val("byp_porta2", gpio_ext_porta, 32'h0);
         if (k == 3) check_val("byp_porta3", gpio_ext_porta, 32'h20);
         if (k == 3) check_val("byp_chg3", gpio_in_chg, 32'h20);
         if (k == 4) check_val("byp_chg4", gpio_in_chg, 32'h0);
      end

      // Filter accept on bit 0: div 3, thresh 2.
      db_en     = 32'h1;
      db_div    = 16'd3;
      db_thresh = 4'd2;
      repeat (6) cyc();
      pad_in    = 32'h21;
      rise      = 0;
      last_tick = -1;
      tick_gap  = 0;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         if (db_tick) begin
            if (last_tick >= 0) tick_gap = k - last_tick;
            last_tick = k;
         end
         if (gpio_ext_porta[0] && rise == 0) rise = k;
      end
      check_val("acc_window", {31'b0, (rise >= 11 && rise <= 14)}, 32'd1);
      check_val("tick_period", tick_gap, 32'd4);

      // Glitch reject: return low, then a 6-cycle high pulse.
      pad_in = 32'h20;
      repeat (16) cyc();
      check_val("glitch_pre", {31'b0, gpio_ext_porta[0]}, 32'd0);
      pulses = 0;
      pad_in = 32'h21;
      for (int k = 0; k < 6; k++) begin
         cyc();
         if (gpio_in_chg[0]) pulses++;
      end
      pad_in = 32'h20;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (gpio_in_chg[0]) pulses++;
      end
      check_val("glitch_pulses", pulses, 32'd0);
      check_val("glitch_porta", {31'b0, gpio_ext_porta[0]}, 32'd0);
      check_val("glitch_cnt", {28'b0, m_cnt[0]}, 32'd0);

      // Runtime threshold drop mid-count.
      pad_in = 32'h21;
      repeat (7) cyc();
      check_val("thr_mid", {31'b0, gpio_ext_porta[0]}, 32'd0);
      db_thresh = 4'd0;
      rise = 0;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         if (gpio_ext_porta[0] && rise == 0) rise = k;
      end
      check_val("thr_drop", {31'b0, (rise >= 1 && rise <= 4)}, 32'd1);
      db_thresh = 4'd2;
      pad_in = 32'h20;
      repeat (16) cyc();
      check_val("thr_fall", {31'b0, gpio_ext_porta[0]}, 32'd0);

      // Clearing db_en mid-count loads sync2 at the next edge.
      pad_in = 32'h21;
      repeat (7) cyc();
      check_val("en_mid", {31'b0, gpio_ext_porta[0]}, 32'd0);
      db_en = 32'h0;
      cyc();
      check_val("en_clr_porta", {31'b0, gpio_ext_porta[0]}, 32'd1);
      check_val("en_clr_chg", {31'b0, gpio_in_chg[0]}, 32'd1);
      db_en = 32'h1;
      repeat (3) cyc();

      // Async reset while bit 0 has a partial count of 2.
      pad_in = 32'h20;
      hit = 1'b0;
      for (int k = 0; k < 20 && !hit; k++) begin
         cyc();
         if (m_cnt[0] == 4'd2) hit = 1'b1;
      end
      check_val("cnt2_reached", {31'b0, hit}, 32'd1);
      pad_in = 32'h21;
      #2;
      presetn = 1'b0;
      #1;
      check_zero("async_rst");
      model_reset();
      repeat (2) @(posedge pclk);
      #1;
      check_zero("rst_hold");
      presetn = 1'b1;
      rise = 0;
      for (int k = 1; k <= 16; k++) begin
         cyc();
         if (gpio_ext_porta[0] && rise == 0) rise = k;
      end
      check_val("post_rst_rise", rise, 32'd12);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
